jtag_dma_ctrl: RTL
==================

# jtag_dma_ctrl

Bus-master sequencer behind the JTAG chain-1 ping-pong buffer. It accepts one-cycle read/write launch pulses from chain 1 and runs one burst transaction on the system bus. Write bursts stream words out of the controller's half of the ping-pong buffer; read bursts store returned words into that half. It drives `switch_ready` so chain 1 only swaps buffer halves while no burst is in flight.

## Interface
Parameters:
- `BUF_AW`, 9: ping-pong buffer address width; only the low 8 bits are used (256 words max).

Ports:
- `JTCK`  in  1  clock, shared with chain 1; all inputs are synchronous to it.
- `JRSTN`  in  1  reset, asynchronous, active-low.
- `cmd_address`  in  32  burst start address; sampled on a launch pulse.
- `cmd_byte_enable`  in  4  byte enables; sampled on a launch pulse.
- `cmd_burst_size`  in  8  words minus 1; sampled on a launch pulse.
- `cmd_write`  in  1  one-cycle write-launch pulse.
- `cmd_read`  in  1  one-cycle read-launch pulse.
- `switch_ready`  out  1  high only in IDLE.
- `busy`  out  1  high whenever not in IDLE.
- `error`  out  1  sticky bus-error flag; cleared by the next accepted launch.
- `pp_address`  out  BUF_AW  buffer address; bit 8 is always 0.
- `pp_writeEnable`  out  1  buffer write strobe.
- `pp_dataIn`  out  32  buffer write data.
- `pp_dataOut`  in  32  buffer read data; valid 1 cycle after the address is presented.
- `bus_request`  out  1  bus request.
- `bus_grant`  in  1  bus grant.
- `bus_begin_transaction`  out  1  one-cycle qualifier for the fields below.
- `bus_address`  out  32  burst address.
- `bus_byte_enable`  out  4  byte enables.
- `bus_burst_size`  out  8  words minus 1.
- `bus_read_n_write`  out  1  1 = read burst.
- `bus_data_out`  out  32  write data.
- `bus_data_valid`  out  1  write data valid.
- `bus_busy`  in  1  write-data stall.
- `bus_end_transaction`  out  1  one-cycle end-of-write-burst pulse.
- `bus_data_in`  in  32  read data.
- `bus_data_in_valid`  in  1  read data valid.
- `bus_end_transaction_in`  in  1  end of read burst from the slave.
- `bus_error`  in  1  slave error; aborts the burst.

## Operation
- Launch acceptance:
  - Launches are accepted only in IDLE.
  - `cmd_write` has priority over `cmd_read` when both pulse together; the read is dropped.
  - Pulses arriving while busy are ignored.
  - An accepted launch latches address, byte enables, size and direction, clears `index` (8 bit) and `error`, and moves to REQ.
- States and transitions:
  - IDLE -> REQ on an accepted launch.
  - REQ: `bus_request`=1. On `bus_grant` -> BEGIN.
  - BEGIN: `bus_begin_transaction`=1 and the latched fields are driven for exactly one cycle. Then write -> WR_FETCH (with `pp_address`=0 presented); read -> RD_DATA.
  - WR_FETCH: one-cycle buffer latency; captures `pp_dataOut` into the data register -> WR_DATA.
  - WR_DATA: `bus_data_valid`=1, `bus_data_out` = data register.
    - When `bus_busy`=0 the word is accepted.
    - If `index`==size -> WR_END.
    - Otherwise increment `index`, present `pp_address`=`index`+1 -> WR_FETCH.
    - While `bus_busy`=1, hold all outputs.
  - WR_END: `bus_end_transaction`=1 for one cycle -> IDLE.
  - RD_DATA: each `bus_data_in_valid` produces `pp_writeEnable`=1, `pp_address`=`index`, `pp_dataIn`=`bus_data_in` in the same cycle (combinational), then increments `index`.
    - `bus_end_transaction_in` -> IDLE.
    - Valid data together with the end signal is still written.
- `bus_request` is asserted in REQ, BEGIN, WR_*, and RD_DATA. It drops in the cycle the FSM enters IDLE.
- Bus error in any non-IDLE state other than REQ:
  - set `error`=1;
  - no buffer write in that cycle;
  - no `bus_end_transaction`;
  - next state IDLE.
- Arithmetic:
  - `index` is 8 bits, so a read burst over 256 words wraps to 0.
  - Word count = `cmd_burst_size` + 1; size 0 means one word, size 255 means 256 words.
- Every bus and buffer output not listed as active in the current state is 0.

## Timing
- Reset values: all outputs 0 except `switch_ready`=1; state IDLE; `error`=0.
- Reset mid-burst returns to IDLE immediately and drops `bus_request` with no end pulse.
- Launch pulse at cycle t: REQ at t+1; `bus_request`=1 from t+1.
- Grant at cycle g (in REQ): begin pulse at g+1.
- Write throughput: 2 cycles per word with no stall.
  - First `bus_data_valid` appears at begin+2.
  - `bus_end_transaction` appears 1 cycle after the last accepted word.
- Read: buffer write occurs in the same cycle as `bus_data_in_valid`.
- `switch_ready` rises in the first IDLE cycle.

## Test plan
- Write, size 3, addr 0x1000_0000, BE 0xF, buffer preloaded with 0xA0..0xA3, grant after 2 cycles, no stall -> one begin pulse (rnw=0, size 3); data 0xA0..0xA3 on consecutive even cycles; end pulse; `switch_ready` high after the end pulse.
- Write, size 1, `bus_busy` high for 3 cycles on word 0 -> word 0 held stable for 3 cycles; exactly 2 words transferred; `index` not advanced during the stall.
- Read, size 255, slave returns data=i for i in 0..255, then end -> buffer addresses 0..255 written with i; `pp_address` bit 8 always 0; state IDLE after end.
- `cmd_write` and `cmd_read` pulsed in the same cycle -> write burst only; a second `cmd_read` pulse during the burst is ignored.
- Read with `bus_error` at the 3rd word -> `error`=1; only 2 buffer writes; `bus_request` drops the next cycle. The next launch clears `error`.
- `JRSTN` asserted in WR_DATA -> all outputs at reset values asynchronously; a new write after release runs normally.

Source files
------------

// File: rtl/jtag_dma_ctrl.sv
// rtl/jtag_dma_ctrl.sv - JTAG chain-1 burst sequencer between ping-pong buffer and system bus
module jtag_dma_ctrl #(
  parameter int BUF_AW = 9
) (
  input  logic              JTCK,
  input  logic              JRSTN,
  input  logic [31:0]       cmd_address,
  input  logic [3:0]        cmd_byte_enable,
  input  logic [7:0]        cmd_burst_size,
  input  logic              cmd_write,
  input  logic              cmd_read,
  output logic              switch_ready,
  output logic              busy,
  output logic              error,
  output logic [BUF_AW-1:0] pp_address,
  output logic              pp_writeEnable,
  output logic [31:0]       pp_dataIn,
  input  logic [31:0]       pp_dataOut,
  output logic              bus_request,
  input  logic              bus_grant,
  output logic              bus_begin_transaction,
  output logic [31:0]       bus_address,
  output logic [3:0]        bus_byte_enable,
  output logic [7:0]        bus_burst_size,
  output logic              bus_read_n_write,
  output logic [31:0]       bus_data_out,
  output logic              bus_data_valid,
  input  logic              bus_busy,
  output logic              bus_end_transaction,
  input  logic [31:0]       bus_data_in,
  input  logic              bus_data_in_valid,
  input  logic              bus_end_transaction_in,
  input  logic              bus_error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_BEGIN,
    S_WR_FETCH,
    S_WR_DATA,
    S_WR_END,
    S_RD_DATA
  } state_t;

  state_t      r_state;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [7:0]  r_size;
  logic        r_rnw;
  logic [7:0]  r_index;
  logic [31:0] r_data;
  logic        r_error;

  logic [7:0]  w_index_next;
  logic        w_rd_write;
  logic        w_wr_last;
  logic [7:0]  w_pp_addr;

  assign w_index_next = r_index + 8'd1;
  assign w_wr_last    = (r_index == r_size);
  // Read data is written straight through; an erroring beat is dropped.
  assign w_rd_write   = (r_state == S_RD_DATA) && bus_data_in_valid && !bus_error;

  // Burst sequencer: launch capture, bus handshake, word transfer and index tracking.
  always_ff @(posedge JTCK or negedge JRSTN) begin
    if (!JRSTN) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_be    <= '0;
      r_size  <= '0;
      r_rnw   <= 1'b0;
      r_index <= '0;
      r_data  <= '0;
      r_error <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Write wins over a simultaneous read; the read is simply dropped.
          if (cmd_write || cmd_read) begin
            r_addr  <= cmd_address;
            r_be    <= cmd_byte_enable;
            r_size  <= cmd_burst_size;
            r_rnw   <= !cmd_write;
            r_index <= '0;
            r_error <= 1'b0;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (bus_grant) r_state <= S_BEGIN;
        end
        S_BEGIN: begin
          if (bus_error) begin
            r_error <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_state <= r_rnw ? S_RD_DATA : S_WR_FETCH;
          end
        end
        S_WR_FETCH: begin
          if (bus_error) begin
            r_error <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_data  <= pp_dataOut;
            r_state <= S_WR_DATA;
          end
        end
        S_WR_DATA: begin
          if (bus_error) begin
            r_error <= 1'b1;
            r_state <= S_IDLE;
          end else if (!bus_busy) begin
            if (w_wr_last) begin
              r_state <= S_WR_END;
            end else begin
              r_index <= w_index_next;
              r_state <= S_WR_FETCH;
            end
          end
        end
        S_WR_END: begin
          if (bus_error) r_error <= 1'b1;
          r_state <= S_IDLE;
        end
        S_RD_DATA: begin
          if (bus_error) begin
            r_error <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            if (bus_data_in_valid) r_index <= w_index_next;
            if (bus_end_transaction_in) r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Buffer address: read beats write at index; write bursts prefetch the next word,
  // which stays stable while the bus stalls.
  always_comb begin
    w_pp_addr = 8'd0;
    if (w_rd_write) begin
      w_pp_addr = r_index;
    end else if ((r_state == S_WR_DATA) && !w_wr_last) begin
      w_pp_addr = w_index_next;
    end
  end

  assign pp_address     = BUF_AW'(w_pp_addr);
  assign pp_writeEnable = w_rd_write;
  assign pp_dataIn      = w_rd_write ? bus_data_in : 32'd0;

  assign switch_ready = (r_state == S_IDLE);
  assign busy         = (r_state != S_IDLE);
  assign error        = r_error;
  assign bus_request  = (r_state != S_IDLE);

  assign bus_begin_transaction = (r_state == S_BEGIN);
  assign bus_address           = bus_begin_transaction ? r_addr : 32'd0;
  assign bus_byte_enable       = bus_begin_transaction ? r_be : 4'd0;
  assign bus_burst_size        = bus_begin_transaction ? r_size : 8'd0;
  assign bus_read_n_write      = bus_begin_transaction && r_rnw;

  assign bus_data_valid      = (r_state == S_WR_DATA);
  assign bus_data_out        = bus_data_valid ? r_data : 32'd0;
  assign bus_end_transaction = (r_state == S_WR_END) && !bus_error;

endmodule
